// File: rtl/dot_pkg.sv
// Shared constants and FSM state type for the dot line renderer.
// Optional feature macro used by the top: DOT_LINE_COUNT_EN.
package dot_pkg;
   localparam int COORD_W = 10;
   localparam logic [COORD_W-1:0] OFFSCREEN = '1;

   // MMIO address window bases for the X and Y coordinate tables
   localparam int X_BASE = 100;
   localparam int Y_BASE = 550;

   typedef enum logic [1:0] {CLEAR, IDLE, SCAN} state_t;
endpackage

// File: rtl/dot_coord_ram.sv
// Paired X/Y coordinate tables: one write port, one combinational indexed read.
// A read of the entry being written returns the old value (read-before-write).
module dot_coord_ram
   import dot_pkg::*;
#(
   parameter int NUM_DOTS = 450,
   parameter int IDX_W    = $clog2(NUM_DOTS)
) (
   input  logic                 clock,
   input  logic                 wr_en,
   input  logic                 wr_both,
   input  logic                 wr_is_y,
   input  logic [IDX_W-1:0]     wr_id,
   input  logic [COORD_W-1:0]   wr_data,
   input  logic [IDX_W-1:0]     rd_id,
   output logic [2*COORD_W-1:0] rd_xy
);
   logic [COORD_W-1:0] x_mem [NUM_DOTS];
   logic [COORD_W-1:0] y_mem [NUM_DOTS];

   // wr_both lets the post-reset clear wipe X and Y in one pass
   always_ff @(posedge clock) begin
      if (wr_en) begin
         if (wr_both || !wr_is_y) x_mem[wr_id] <= wr_data;
         if (wr_both ||  wr_is_y) y_mem[wr_id] <= wr_data;
      end
   end

   assign rd_xy = {x_mem[rd_id], y_mem[rd_id]};
endmodule

// File: rtl/dot_line_renderer.sv
// Captures dot coordinate writes, scans the table once per line into a back
// bitmap, serves the front bitmap to the pixel pipe. Macro: DOT_LINE_COUNT_EN.
module dot_line_renderer
   import dot_pkg::*;
#(
   parameter int NUM_DOTS = 450,
   parameter int H_ACTIVE = 640,
   parameter int DOT_SIZE = 2
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               dotWren,
   input  logic               is_Yloc,
   input  logic [31:0]        dotID,
   input  logic [31:0]        dotLoc,
   input  logic               line_start,
   input  logic [COORD_W-1:0] line_y,
   input  logic               pix_valid,
   input  logic [COORD_W-1:0] pix_x,
   output logic               pix_hit,
   output logic               prep_busy,
   output logic               prep_done,
   output logic               overrun,
   output logic               clear_busy
`ifdef DOT_LINE_COUNT_EN
   ,
   output logic [COORD_W-1:0] line_count
`endif
);
   localparam int IDX_W = $clog2(NUM_DOTS);
   localparam logic [IDX_W-1:0]   LAST   = IDX_W'(NUM_DOTS - 1);
   localparam logic [COORD_W:0]   H_LIM  = (COORD_W+1)'(H_ACTIVE);
   localparam logic [COORD_W:0]   DS_EXT = (COORD_W+1)'(DOT_SIZE);
   localparam logic [H_ACTIVE-1:0] DOT_BITS =
      {{(H_ACTIVE-DOT_SIZE){1'b0}}, {DOT_SIZE{1'b1}}};

   state_t                     state;
   logic [IDX_W-1:0]           idx;
   logic [COORD_W-1:0]         ly;
   logic                       front_sel;
   logic [1:0][H_ACTIVE-1:0]   bmp;

   logic                       cpu_wr, clearing, hit;
   logic [2*COORD_W-1:0]       rd_xy;
   logic [COORD_W-1:0]         rd_x, rd_y;
   logic [COORD_W:0]           y_ext, ly_ext;
   logic [H_ACTIVE-1:0]        hit_mask;
   logic                       unused_loc_hi;

   assign unused_loc_hi = ^dotLoc[31:COORD_W];
   assign clearing = (state == CLEAR);
   assign cpu_wr   = dotWren && (dotID < 32'(NUM_DOTS)) && !clearing;

   dot_coord_ram #(.NUM_DOTS(NUM_DOTS), .IDX_W(IDX_W)) u_ram (
      .clock   (clock),
      .wr_en   (clearing || cpu_wr),
      .wr_both (clearing),
      .wr_is_y (is_Yloc),
      .wr_id   (clearing ? idx : dotID[IDX_W-1:0]),
      .wr_data (clearing ? OFFSCREEN : dotLoc[COORD_W-1:0]),
      .rd_id   (idx),
      .rd_xy   (rd_xy)
   );

   assign {rd_x, rd_y} = rd_xy;
   assign y_ext  = {1'b0, rd_y};
   assign ly_ext = {1'b0, ly};
   // One extra bit keeps y + DOT_SIZE from wrapping near OFFSCREEN
   assign hit = (state == SCAN) && (y_ext <= ly_ext) && (ly_ext < y_ext + DS_EXT)
                && ({1'b0, rd_x} < H_LIM);
   // Shifting past bit H_ACTIVE-1 clips dots at the right edge
   assign hit_mask = hit ? (DOT_BITS << rd_x) : '0;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state      <= CLEAR;
         idx        <= '0;
         ly         <= '0;
         front_sel  <= 1'b0;
         bmp        <= '0;
         prep_busy  <= 1'b0;
         prep_done  <= 1'b0;
         overrun    <= 1'b0;
         clear_busy <= 1'b1;
      end else begin
         prep_done <= 1'b0;
         case (state)
            CLEAR: begin
               idx <= idx + 1'b1;
               if (idx == LAST) begin
                  idx        <= '0;
                  state      <= IDLE;
                  clear_busy <= 1'b0;
               end
            end
            default: begin
               if (line_start) begin
                  if (state == SCAN) overrun <= 1'b1;
                  front_sel      <= ~front_sel;
                  bmp[front_sel] <= '0;
                  ly             <= line_y;
                  idx            <= '0;
                  state          <= SCAN;
                  prep_busy      <= 1'b1;
               end else if (state == SCAN) begin
                  bmp[~front_sel] <= bmp[~front_sel] | hit_mask;
                  if (idx == LAST) begin
                     state     <= IDLE;
                     prep_busy <= 1'b0;
                     prep_done <= 1'b1;
                  end else begin
                     idx <= idx + 1'b1;
                  end
               end
            end
         endcase
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) pix_hit <= 1'b0;
      else       pix_hit <= pix_valid && ({1'b0, pix_x} < H_LIM) && bmp[front_sel][pix_x];
   end

`ifdef DOT_LINE_COUNT_EN
   logic [COORD_W-1:0] hit_cnt, cnt_next;
   assign cnt_next = (hit && hit_cnt != '1) ? hit_cnt + 1'b1 : hit_cnt;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         hit_cnt    <= '0;
         line_count <= '0;
      end else if (!clearing && line_start) begin
         hit_cnt <= '0;
      end else if (state == SCAN) begin
         hit_cnt <= cnt_next;
         if (idx == LAST) line_count <= cnt_next;
      end
   end
`endif
endmodule

// File: tb/tb_dot_line_renderer.sv
// Directed bench for dot_line_renderer: clear timing, scan latency, buffer
// swap, clipping, ID range, overrun, read-before-write and mid-scan reset.
module tb_dot_line_renderer;
   import dot_pkg::*;

   logic               clock = 1'b0, reset = 1'b1;
   logic               dotWren = 1'b0, is_Yloc = 1'b0;
   logic [31:0]        dotID = '0, dotLoc = '0;
   logic               line_start = 1'b0, pix_valid = 1'b0;
   logic [COORD_W-1:0] line_y = '0, pix_x = '0;
   logic               pix_hit, prep_busy, prep_done, overrun, clear_busy;
`ifdef DOT_LINE_COUNT_EN
   logic [COORD_W-1:0] line_count;
`endif

   int checks = 0, fails = 0;
   int n, lat;
   logic seen_done, seen_busy;

   dot_line_renderer dut (
      .clock(clock), .reset(reset), .dotWren(dotWren), .is_Yloc(is_Yloc),
      .dotID(dotID), .dotLoc(dotLoc), .line_start(line_start), .line_y(line_y),
      .pix_valid(pix_valid), .pix_x(pix_x), .pix_hit(pix_hit),
      .prep_busy(prep_busy), .prep_done(prep_done), .overrun(overrun),
      .clear_busy(clear_busy)
`ifdef DOT_LINE_COUNT_EN
      , .line_count(line_count)
`endif
   );

   always #5 clock = ~clock;

   task automatic tick;
      @(posedge clock); #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wr(input int id, input logic isy, input int loc);
      dotWren = 1'b1; dotID = id; is_Yloc = isy; dotLoc = loc;
      tick;
      dotWren = 1'b0;
   endtask

   task automatic start(input int y);
      line_start = 1'b1; line_y = COORD_W'(y);
      tick;
      line_start = 1'b0;
   endtask

   task automatic wait_done(output int l);
      l = 1;
      while (prep_done !== 1'b1 && l < 2000) begin
         tick; l++;
      end
   endtask

   task automatic pix(input string tag, input int x, input logic exp);
      pix_valid = 1'b1; pix_x = COORD_W'(x);
      tick;
      chk(tag, pix_hit, exp);
      pix_valid = 1'b0;
   endtask

   initial begin
      tick; tick;
      chk("rst_pix_hit", pix_hit, 0);
      chk("rst_prep_busy", prep_busy, 0);
      chk("rst_prep_done", prep_done, 0);
      chk("rst_overrun", overrun, 0);
      chk("rst_clear_busy", clear_busy, 1);

      // clear phase: count cycles, line_start mid-clear must be ignored
      @(negedge clock); reset = 1'b0;
      n = 0; seen_done = 1'b0; seen_busy = 1'b0;
      while (clear_busy === 1'b1 && n < 1000) begin
         line_start = (n == 10); line_y = 21;
         @(posedge clock); #1; n++;
         if (prep_done === 1'b1) seen_done = 1'b1;
         if (prep_busy === 1'b1) seen_busy = 1'b1;
      end
      line_start = 1'b0;
      repeat (10) begin
         tick;
         if (prep_done === 1'b1) seen_done = 1'b1;
      end
      chk("clear_cycles", n, 450);
      chk("clear_no_done", seen_done, 0);
      chk("clear_no_busy", seen_busy, 0);

      // dot 3 at (10,20) drawn on line 21
      wr(3, 0, 10); wr(3, 1, 20);
      start(21);
      chk("scan_busy", prep_busy, 1);
      wait_done(lat);
      chk("scan_latency", lat, 451);
      tick;
      chk("done_single", prep_done, 0);
      chk("idle_not_busy", prep_busy, 0);
      start(0);
      pix("l21_x10", 10, 1);
      pix("l21_x11", 11, 1);
      pix("l21_x9", 9, 0);
      pix("l21_x12", 12, 0);
      pix_x = 10; tick;
      chk("l21_novalid", pix_hit, 0);
      pix("l21_x700", 700, 0);
      wait_done(lat);

      // right-edge clipping and out-of-range IDs
      wr(5, 0, 639); wr(5, 1, 5);
      wr(450, 0, 7); wr(515, 1, 5);
      start(5); wait_done(lat);
      start(100);
      pix("l5_x639", 639, 1);
      pix("l5_x638", 638, 0);
      pix("l5_x10", 10, 0);
      pix("l5_x640", 640, 0);
      wait_done(lat);
      chk("no_overrun_yet", overrun, 0);

      // line_start 100 cycles into a scan
      start(21);
      repeat (99) tick;
      start(5);
      chk("overrun_set", overrun, 1);
      wait_done(lat);
      chk("overrun_latency", lat, 451);
      chk("overrun_sticky", overrun, 1);
      pix("partial_x10", 10, 1);
      pix("partial_x639", 639, 0);
      start(100);
      pix("after_ovr_x639", 639, 1);
      pix("after_ovr_x10", 10, 0);
      wait_done(lat);

      // Y write to dot 0 in the cycle the scan reads entry 0
      wr(0, 0, 300);
      start(60);
      dotWren = 1'b1; is_Yloc = 1'b1; dotID = 0; dotLoc = 60;
      tick;
      dotWren = 1'b0;
      wait_done(lat);
      start(60);
      pix("rbw_old_y", 300, 0);
      wait_done(lat);
      start(100);
      pix("rbw_new_y", 300, 1);
      wait_done(lat);

`ifdef DOT_LINE_COUNT_EN
      chk("count_zero", line_count, 0);
      wr(10, 0, 100); wr(10, 1, 40);
      wr(11, 0, 200); wr(11, 1, 40);
      wr(12, 0, 300); wr(12, 1, 40);
      start(40); wait_done(lat);
      chk("count_three", line_count, 3);
`endif

      // reset in the middle of a scan
      start(21);
      repeat (50) tick;
      reset = 1'b1; #1;
      chk("mid_rst_clear_busy", clear_busy, 1);
      chk("mid_rst_prep_busy", prep_busy, 0);
      chk("mid_rst_overrun", overrun, 0);
      chk("mid_rst_pix_hit", pix_hit, 0);
      @(negedge clock); reset = 1'b0;
      n = 0;
      while (clear_busy === 1'b1 && n < 1000) begin
         tick; n++;
      end
      chk("reclear_cycles", n, 450);
      start(21); wait_done(lat);
      start(100);
      pix("reclear_x10", 10, 0);
      wait_done(lat);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
